rgmii_tx_sched: RTL

RGMII_TX_SCHED -- requirements
Module: rgmii_tx_sched

---
 rtl/rgmii_tx_sched_pkg.sv | 44 ++++
 rtl/rgmii_rr_arb2.sv | 40 ++++
 rtl/rgmii_tx_sched.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_tx_sched_pkg.sv
// rgmii_tx_sched_pkg
// Shared definitions for the RGMII transmit scheduler:
//   - FSM state encoding (state_t + ST_* constants)
//   - framing bytes (preamble 0x55, SFD 0xD5)
//   - PHY speed codes and cycles-per-byte at each speed
//   - gap_load(): inter-frame gap length in 125 MHz cycles
package rgmii_tx_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_PREAMBLE = 3'd1;
    localparam state_t ST_SFD      = 3'd2;
    localparam state_t ST_DATA     = 3'd3;
    localparam state_t ST_DROP     = 3'd4;
    localparam state_t ST_IFG      = 3'd5;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [1:0] SPEED_10M   = 2'd0;
    localparam logic [1:0] SPEED_100M  = 2'd1;
    localparam logic [1:0] SPEED_1000M = 2'd2;

    // One byte-time measured in 125 MHz cycles.
    localparam int CPB_10M   = 100;
    localparam int CPB_100M  = 10;
    localparam int CPB_1000M = 1;

    // 11 bits holds the worst case of 12 byte-times at 10M (1200 cycles).
    localparam int GAP_W = 11;

    // The unused speed code 3 is treated as gigabit (shortest gap).
    function automatic logic [GAP_W-1:0] gap_load(input int ifg_bytes, input logic [1:0] speed);
        int cpb;
        case (speed)
            SPEED_10M:  cpb = CPB_10M;
            SPEED_100M: cpb = CPB_100M;
            default:    cpb = CPB_1000M;
        endcase
        return GAP_W'(ifg_bytes * cpb);
    endfunction

endpackage

// File: rtl/rgmii_rr_arb2.sv
// rgmii_rr_arb2
// Two-requester round-robin selector, decided once per frame.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (last grant -> requester 1)
//   req_i    : request bits, [0] = source 0, [1] = source 1
//   take_i   : the caller commits to grant_o this cycle; updates history
//   grant_o  : one-hot winner (combinational), 0 when nobody requests
module rgmii_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] grant_o
);

    // 1 = source 1 won the previous frame, so source 0 is next in line.
    logic last_q;
    logic last_d;

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    assign last_d = (take_i && (grant_o != 2'b00)) ? grant_o[1] : last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rgmii_tx_sched.sv
// rgmii_tx_sched
// Arbitrates two AXI-Stream frame sources onto one byte stream for an
// RGMII transmitter, prefixing preamble + SFD and enforcing the
// inter-frame gap at the current PHY speed.
//   clk_125mhz       : single clock
//   reset            : synchronous active-high reset
//   phy_link_status  : async link-up flag (synchronized internally)
//   phy_speed_status : async speed code (synchronized internally)
//   s0_axis_*        : frame source 0 (tdata/tvalid/tready/tlast)
//   s1_axis_*        : frame source 1
//   m_axis_*         : byte stream out (tdata/tvalid/tready)
//   tx_grant         : one-hot owner of the frame in flight
//   tx_underrun      : high for each DATA cycle the owner has no byte
//   tx_drop          : one-cycle pulse when link loss discards a frame
//   dbg_state        : current FSM state (ST_* encoding)
//
// Handshake: a byte moves on any cycle where tvalid && tready; a sender
// never withdraws tvalid on its own account except the sources, whose
// missing tvalid mid-frame is reported as underrun rather than hidden.
module rgmii_tx_sched
    import rgmii_tx_sched_pkg::*;
#(
    parameter int IFG_BYTES    = 12,
    parameter int PREAMBLE_LEN = 7   // must be 1..255
) (
    input  logic       clk_125mhz,
    input  logic       reset,
    input  logic       phy_link_status,
    input  logic [1:0] phy_speed_status,
    input  logic [7:0] s0_axis_tdata,
    input  logic       s0_axis_tvalid,
    output logic       s0_axis_tready,
    input  logic       s0_axis_tlast,
    input  logic [7:0] s1_axis_tdata,
    input  logic       s1_axis_tvalid,
    output logic       s1_axis_tready,
    input  logic       s1_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic [1:0] tx_grant,
    output logic       tx_underrun,
    output logic       tx_drop,
    output logic [2:0] dbg_state
);

    logic             link_meta_q, link_sync_q;
    logic [1:0]       speed_meta_q, speed_sync_q;
    state_t           state_q, state_d;
    logic [7:0]       pre_cnt_q, pre_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       arb_grant;
    logic             arb_take;
    logic             src_ready;
    logic [7:0]       src_tdata;
    logic             src_tvalid;
    logic             src_tlast;

    rgmii_rr_arb2 u_arb (
        .clk_i   (clk_125mhz),
        .rst_i   (reset),
        .req_i   ({s1_axis_tvalid, s0_axis_tvalid}),
        .take_i  (arb_take),
        .grant_o (arb_grant)
    );

    // Granted-source view; only meaningful while grant_q is nonzero.
    assign src_tdata  = grant_q[1] ? s1_axis_tdata : s0_axis_tdata;
    assign src_tvalid = (grant_q[0] & s0_axis_tvalid) | (grant_q[1] & s1_axis_tvalid);
    assign src_tlast  = grant_q[1] ? s1_axis_tlast : s0_axis_tlast;

    assign s0_axis_tready = src_ready & grant_q[0];
    assign s1_axis_tready = src_ready & grant_q[1];
    assign tx_grant       = grant_q;
    assign dbg_state      = state_q;

    always_comb begin
        state_d       = state_q;
        pre_cnt_d     = pre_cnt_q;
        gap_d         = gap_q;
        grant_d       = grant_q;
        arb_take      = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        src_ready     = 1'b0;
        tx_underrun   = 1'b0;
        tx_drop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (link_sync_q && (s0_axis_tvalid || s1_axis_tvalid)) begin
                    arb_take  = 1'b1;
                    grant_d   = arb_grant;
                    pre_cnt_d = 8'd0;
                    state_d   = ST_PREAMBLE;
                end
            end

            // Link loss before any payload byte: nothing was taken from the
            // source, so simply release it and start over.
            ST_PREAMBLE: begin
                if (!link_sync_q) begin
                    tx_drop = 1'b1;
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = PREAMBLE_BYTE;
                    if (m_axis_tready) begin
                        if (pre_cnt_q == 8'(PREAMBLE_LEN - 1)) begin
                            pre_cnt_d = 8'd0;
                            state_d   = ST_SFD;
                        end else begin
                            pre_cnt_d = pre_cnt_q + 8'd1;
                        end
                    end
                end
            end

            ST_SFD: begin
                if (!link_sync_q) begin
                    tx_drop = 1'b1;
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = SFD_BYTE;
                    if (m_axis_tready) begin
                        state_d = ST_DATA;
                    end
                end
            end

            // The link-down cycle moves nothing in either direction, so the
            // byte the source is offering becomes the first one DROP eats.
            ST_DATA: begin
                if (!link_sync_q) begin
                    tx_drop = 1'b1;
                    state_d = ST_DROP;
                end else begin
                    m_axis_tvalid = src_tvalid;
                    m_axis_tdata  = src_tdata;
                    src_ready     = m_axis_tready;
                    if (!src_tvalid) begin
                        tx_underrun = 1'b1;
                    end else if (m_axis_tready && src_tlast) begin
                        gap_d   = gap_load(IFG_BYTES, speed_sync_q);
                        grant_d = 2'b00;
                        state_d = ST_IFG;
                    end
                end
            end

            ST_DROP: begin
                src_ready = 1'b1;
                if (src_tvalid && src_tlast) begin
                    gap_d   = gap_load(IFG_BYTES, speed_sync_q);
                    grant_d = 2'b00;
                    state_d = ST_IFG;
                end
            end

            // The gap length was fixed on entry; speed changes now are ignored.
            ST_IFG: begin
                if (gap_q <= 11'd1) begin
                    gap_d   = 11'd0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 11'd1;
                end
            end

            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            link_meta_q  <= 1'b0;
            link_sync_q  <= 1'b0;
            speed_meta_q <= 2'b00;
            speed_sync_q <= 2'b00;
            state_q      <= ST_IDLE;
            pre_cnt_q    <= 8'd0;
            gap_q        <= '0;
            grant_q      <= 2'b00;
        end else begin
            link_meta_q  <= phy_link_status;
            link_sync_q  <= link_meta_q;
            speed_meta_q <= phy_speed_status;
            speed_sync_q <= speed_meta_q;
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            gap_q        <= gap_d;
            grant_q      <= grant_d;
        end
    end

endmodule
